ahb_sram_responder: RTL and testbench

- AHB-Lite responder (slave) for the Cortex-M0 core's bus initiator; it is the memory end of the core's load/store and fetch traffic.
- Provides a word-organised SRAM with byte, halfword and word writes, a configurable number of wait states, and ERROR responses for misaligned or oversize transfers.
- Sits in the top level beside the control unit and datapath. Its hsel comes from the address decoder.

---
 rtl/ahb_pkg.sv | 44 ++++
 rtl/sram_bytelane.sv | 37 +++
 rtl/ahb_sram_responder.sv | 136 +++++++++++++
 tb/tb_ahb_sram_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, responder state encoding and transfer decode helpers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_XFER = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Byte-lane write mask for a transfer of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] ofs);
    lane_mask = 4'b1111;
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << ofs;
      HSIZE_HALF: lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

  // Oversize transfers and misaligned halfword/word transfers are illegal.
  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] ofs);
    case (size)
      HSIZE_BYTE: xfer_legal = 1'b1;
      HSIZE_HALF: xfer_legal = ~ofs[0];
      HSIZE_WORD: xfer_legal = (ofs == 2'b00);
      default:    xfer_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sram_bytelane.sv
// Word-organised SRAM with per-byte write enables and asynchronous read.
module sram_bytelane #(
  parameter int unsigned AW        = 10,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  // Zeroing is an elaboration-time image only; no reset ever touches the array.
  if (INIT_ZERO) begin : g_zero
    logic [31:0] r_mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
        if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end

    assign o_rdata = r_mem[i_raddr];
  end else begin : g_noinit
    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
        if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end

    assign o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/ahb_sram_responder.sv
// AHB-Lite SRAM responder: phase registers, wait-state/error FSM and lane decode
// around a byte-lane SRAM.
module ahb_sram_responder
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          INIT_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned WI_W    = ADDR_W - 2;
  localparam logic [1:0]  WS_LOAD = 2'((WAIT_STATES == 0) ? 0 : (WAIT_STATES - 1));

  state_t            r_state;
  logic [WI_W-1:0]   r_addr;
  logic [3:0]        r_lane;
  logic              r_write;
  logic [1:0]        r_wait_cnt;
  logic              r_hreadyout;
  logic              r_hresp;
  logic [31:0]       r_hrdata;

  logic              w_accept;
  logic              w_legal;
  logic [WI_W-1:0]   w_addr;
  logic [3:0]        w_lane;
  logic [3:0]        w_we;
  logic [WI_W-1:0]   w_raddr;
  logic [31:0]       w_rdata;
  logic [31:0]       w_fwd;
  logic              w_unused;

  assign w_accept = hsel & hready & ((htrans == HTRANS_NONSEQ) | (htrans == HTRANS_SEQ));
  assign w_legal  = xfer_legal(hsize, haddr[1:0]);
  assign w_addr   = haddr[ADDR_W-1:2];
  assign w_lane   = lane_mask(hsize, haddr[1:0]);
  assign w_unused = ^haddr[31:ADDR_W];

  assign w_we    = ((r_state == ST_XFER) && r_write) ? r_lane : 4'b0000;
  assign w_raddr = (r_state == ST_WAIT) ? r_addr : w_addr;

  sram_bytelane #(
    .AW        (WI_W),
    .INIT_ZERO (INIT_ZERO)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (hwdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Read data is registered on entry to XFER, so a write landing on that same edge is merged in.
  always_comb begin
    w_fwd = w_rdata;
    for (int b = 0; b < 4; b++)
      if (w_we[b] && (r_addr == w_raddr)) w_fwd[8*b +: 8] = hwdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_lane      <= '0;
      r_write     <= 1'b0;
      r_wait_cnt  <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
    end else begin
      r_hrdata <= '0;
      case (r_state)
        ST_WAIT: begin
          if (r_wait_cnt == 2'd0) begin
            r_state     <= ST_XFER;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            if (!r_write) r_hrdata <= w_fwd;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= HRESP_ERROR;
        end
        default: begin
          if (w_accept) begin
            r_addr  <= w_addr;
            r_lane  <= w_lane;
            r_write <= hwrite;
            if (!w_legal) begin
              r_state     <= ST_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_ERROR;
            end else if (WAIT_STATES == 0) begin
              r_state     <= ST_XFER;
              r_hreadyout <= 1'b1;
              r_hresp     <= HRESP_OKAY;
              if (!hwrite) r_hrdata <= w_fwd;
            end else begin
              r_state     <= ST_WAIT;
              r_wait_cnt  <= WS_LOAD;
              r_hreadyout <= 1'b0;
              r_hresp     <= HRESP_OKAY;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
          end
        end
      endcase
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = r_hrdata;

endmodule

// File: tb/tb_ahb_sram_responder.sv
// Scoreboard bench for ahb_sram_responder: a byte-addressed reference memory predicts each
// data phase; a per-instance monitor checks the responses. Instance 1 has one wait state, instance 0 none.
module tb_ahb_sram_responder;
  import ahb_pkg::*;

  localparam int unsigned AW     = 12;
  localparam int unsigned NBYTES = 1 << AW;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int unsigned waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];
  txn_t seq[$];
  logic [7:0] ref_mem [2][NBYTES];

  always #5 clk = ~clk;

  ahb_sram_responder #(.ADDR_W(AW), .WAIT_STATES(0), .INIT_ZERO(1'b1)) u_dut0 (
    .clk(clk), .rst(rst_n[0]), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hwdata(hwdata[0]), .hready(hreadyout[0]),
    .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0])
  );

  ahb_sram_responder #(.ADDR_W(AW), .WAIT_STATES(1), .INIT_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst(rst_n[1]), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hwdata(hwdata[1]), .hready(hreadyout[1]),
    .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  function automatic txn_t tx(input logic w, input logic [2:0] s, input logic [31:0] a,
                              input logic [31:0] d, input logic sel = 1'b1,
                              input logic [1:0] tr = HTRANS_NONSEQ);
    txn_t t;
    t.sel = sel; t.trans = tr; t.write = w; t.size = s; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // Reference: byte-addressed memory, transfers complete strictly in order.
  function automatic void model(input int k, input txn_t t);
    exp_t        e;
    int unsigned ba;
    int unsigned wb;
    ba     = t.addr & (NBYTES - 1);
    wb     = ba & ~32'd3;
    e.err  = !((t.size == HSIZE_BYTE) || (t.size == HSIZE_HALF && !t.addr[0]) ||
               (t.size == HSIZE_WORD && t.addr[1:0] == 2'b00));
    e.data = '0;
    e.waits = e.err ? 1 : ((k == 1) ? 1 : 0);
    if (!e.err) begin
      if (t.write) begin
        for (int i = 0; i < (1 << t.size); i++)
          ref_mem[k][ba + i] = t.wdata[8 * ((ba + i) % 4) +: 8];
      end else begin
        for (int i = 0; i < 4; i++) e.data[8*i +: 8] = ref_mem[k][wb + i];
      end
    end
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  task automatic present(input int k, input txn_t t);
    hsel[k] = t.sel; haddr[k] = t.addr; htrans[k] = t.trans; hwrite[k] = t.write; hsize[k] = t.size;
  endtask

  task automatic wait_ready(input int k, output logic rdy);
    int guard = 0;
    do begin
      @(negedge clk); rdy = hreadyout[k];
      @(posedge clk); #1; guard++;
    end while (!rdy && guard < 16);
  endtask

  // Pipelined initiator: the address of the next transfer overlaps the current data phase.
  task automatic run_seq(input int k);
    logic rdy;
    seq.push_back(tx(1'b0, HSIZE_WORD, 32'h0, 32'h0, 1'b0, HTRANS_IDLE));
    foreach (seq[i]) begin
      present(k, seq[i]);
      wait_ready(k, rdy);
      if (!rdy) begin
        vectors++; miscompares++;
        $display("FAIL i%0d accept timeout: hreadyout %0b, expected 1", k, hreadyout[k]);
      end else if (seq[i].sel && seq[i].trans[1]) begin
        model(k, seq[i]);
        hwdata[k] = seq[i].write ? seq[i].wdata : $urandom();
      end
    end
    seq.delete();
  endtask

  task automatic monitor(input int k);
    logic        dp = 1'b0;
    int unsigned lowc = 0;
    logic        lowresp = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n[k]) begin dp = 1'b0; continue; end
      if (dp) begin
        if (!hreadyout[k]) begin
          lowc++; lowresp |= hresp[k];
        end else begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            vectors++; miscompares++;
            $display("FAIL i%0d unexpected data phase: queue empty, expected an entry", k);
          end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("i%0d hresp", k),         32'(hresp[k]), 32'(e.err));
            check($sformatf("i%0d wait cycles", k),   lowc, e.waits);
            check($sformatf("i%0d first-cycle resp", k), 32'(lowresp), 32'(e.err));
            check($sformatf("i%0d hrdata", k),        hrdata[k], e.data);
          end
          dp = 1'b0;
        end
      end else begin
        check($sformatf("i%0d idle ready/resp", k), {30'b0, hreadyout[k], hresp[k]}, 32'h2);
        check($sformatf("i%0d idle hrdata", k), hrdata[k], 32'h0);
      end
      if (hreadyout[k] && hsel[k] && htrans[k][1]) begin
        dp = 1'b1; lowc = 0; lowresp = 1'b0;
      end
    end
  endtask

  function automatic txn_t rnd_txn();
    txn_t        t;
    int unsigned r;
    t.addr  = $urandom() & 32'h0000_307F;
    r       = $urandom_range(0, 11);
    t.size  = (r < 4) ? HSIZE_BYTE : (r < 8) ? HSIZE_HALF : (r < 11) ? HSIZE_WORD
                                                          : 3'($urandom_range(3, 7));
    if ($urandom_range(0, 9) < 8) begin
      if (t.size == HSIZE_HALF) t.addr[0] = 1'b0;
      if (t.size == HSIZE_WORD) t.addr[1:0] = 2'b00;
    end
    t.write = 1'($urandom_range(0, 1));
    t.wdata = $urandom();
    t.sel   = ($urandom_range(0, 9) != 0);
    t.trans = ($urandom_range(0, 9) == 0) ? ($urandom_range(0, 1) ? HTRANS_BUSY : HTRANS_IDLE)
                                          : ($urandom_range(0, 1) ? HTRANS_SEQ : HTRANS_NONSEQ);
    return t;
  endfunction

  // Reset lands in the WAIT cycle of a write: the write must be dropped.
  task automatic reset_abort();
    logic rdy;
    present(1, tx(1'b1, HSIZE_WORD, 32'h030, 32'h0));
    wait_ready(1, rdy);
    check("i1 abort accept", 32'(rdy), 32'h1);
    hwdata[1] = 32'h5566_7788;
    present(1, tx(1'b0, HSIZE_WORD, 32'h0, 32'h0, 1'b0, HTRANS_IDLE));
    check("i1 abort in wait", 32'(hreadyout[1]), 32'h0);
    #1 rst_n[1] = 1'b0;
    #1;
    check("i1 reset ready/resp", {30'b0, hreadyout[1], hresp[1]}, 32'h2);
    check("i1 reset hrdata", hrdata[1], 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; hsel[k] = 1'b0; haddr[k] = '0; htrans[k] = HTRANS_IDLE;
      hwrite[k] = 1'b0; hsize[k] = HSIZE_WORD; hwdata[k] = '0;
      for (int a = 0; a < int'(NBYTES); a++) ref_mem[k][a] = 8'h00;
    end
    fork
      monitor(0);
      monitor(1);
    join_none

    #12;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("i%0d reset ready/resp", k), {30'b0, hreadyout[k], hresp[k]}, 32'h2);
      check($sformatf("i%0d reset hrdata", k), hrdata[k], 32'h0);
    end
    @(negedge clk); rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    // One wait state: word, byte, halfword, misaligned, not-selected and alias traffic.
    seq.push_back(tx(1'b1, HSIZE_WORD, 32'h010, 32'hDEAD_BEEF));
    seq.push_back(tx(1'b0, HSIZE_WORD, 32'h010, 32'h0));
    seq.push_back(tx(1'b1, HSIZE_BYTE, 32'h013, 32'hAA00_0000));
    seq.push_back(tx(1'b0, HSIZE_WORD, 32'h010, 32'h0));
    seq.push_back(tx(1'b1, HSIZE_HALF, 32'h010, 32'h0000_1234));
    seq.push_back(tx(1'b0, HSIZE_WORD, 32'h010, 32'h0));
    seq.push_back(tx(1'b1, HSIZE_WORD, 32'h012, 32'h1111_1111));
    seq.push_back(tx(1'b0, HSIZE_WORD, 32'h010, 32'h0));
    seq.push_back(tx(1'b1, HSIZE_WORD, 32'h010, 32'h2222_2222, 1'b1, HTRANS_BUSY));
    seq.push_back(tx(1'b1, HSIZE_WORD, 32'h010, 32'h3333_3333, 1'b0, HTRANS_NONSEQ));
    seq.push_back(tx(1'b0, HSIZE_WORD, 32'h010, 32'h0));
    seq.push_back(tx(1'b1, HSIZE_WORD, 32'h1010, 32'hCAFE_F00D));
    seq.push_back(tx(1'b0, HSIZE_WORD, 32'h010, 32'h0));
    seq.push_back(tx(1'b1, HSIZE_WORD, 32'h030, 32'h1122_3344));
    run_seq(1);
    reset_abort();
    seq.push_back(tx(1'b0, HSIZE_WORD, 32'h030, 32'h0));
    run_seq(1);

    // Zero wait states: back-to-back SEQ writes then reads, plus write-then-read of one word.
    for (int i = 0; i < 4; i++)
      seq.push_back(tx(1'b1, HSIZE_WORD, 32'h020 + 32'(4*i), 32'hA5A5_0000 + 32'(i), 1'b1,
                       (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ));
    for (int i = 0; i < 4; i++)
      seq.push_back(tx(1'b0, HSIZE_WORD, 32'h020 + 32'(4*i), 32'h0, 1'b1,
                       (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ));
    seq.push_back(tx(1'b1, HSIZE_BYTE, 32'h02D, 32'h0000_7700));
    seq.push_back(tx(1'b0, HSIZE_WORD, 32'h02C, 32'h0));
    run_seq(0);

    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 150; n++) seq.push_back(rnd_txn());
      run_seq(k);
    end

    repeat (4) @(posedge clk);
    check("i0 scoreboard drained", 32'(q0.size()), 32'h0);
    check("i1 scoreboard drained", 32'(q1.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
